xadc_channel_scheduler: RTL and testbench
=========================================

XADC_CHANNEL_SCHEDULER -- requirements
Module: xadc_channel_scheduler

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of auxiliary channels scanned (2..8).
REQ-002 SHALL provide parameter BASE_ADDR, default 7'h10, DRP address of aux channel 0; channel k at BASE_ADDR+k.
REQ-003 SHALL provide parameter LOW_TH, default 12'hE1A, assert threshold for voltage_low.
REQ-004 SHALL provide parameter HIGH_TH, default 12'hE3C, release threshold for voltage_low.
REQ-005 SHALL provide parameter TIMEOUT, default 63, max cycles waited for drdy_in after a read request.
REQ-006 SHALL have one clock and an asynchronous active-high reset:
- clk  input  1  sole clock, all state on rising edge
- reset_in  input  1  asynchronous, active-high reset
- eoc_in  input  1  ADC end-of-conversion strobe
- den_out  output  1  DRP read enable, one-cycle pulse
- daddr_out  output  7  DRP address
- drdy_in  input  1  DRP data-ready
- do_in  input  16  DRP read data, result in [15:4]
- sample_out  output  12  last captured result
- sample_ch_out  output  3  channel index of sample_out
- sample_valid  output  1  one-cycle pulse on new sample
- voltage_low  output  NUM_CH  per-channel hysteresis flag
- timeout_err  output  1  sticky DRP-timeout flag
- busy  output  1  high when not in IDLE

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, UPDATE.
REQ-008 SHALL move IDLE->ISSUE on eoc_in high; eoc_in in any other state SHALL be ignored (not queued).
REQ-009 SHALL in ISSUE drive den_out=1 for exactly one cycle with daddr_out=BASE_ADDR+ch, then enter WAIT.
REQ-010 SHALL hold daddr_out stable from ISSUE until leaving WAIT.
REQ-011 SHALL in WAIT, on drdy_in high, capture do_in[15:4] into sample_out and ch into sample_ch_out, enter UPDATE.
REQ-012 SHALL ignore drdy_in in IDLE, ISSUE and UPDATE.
REQ-013 SHALL count WAIT cycles from 0; if count reaches TIMEOUT with no drdy_in, set timeout_err, leave sample_out/voltage_low unchanged, advance ch, return to IDLE.
REQ-014 SHALL, if drdy_in arrives in the same cycle the count reaches TIMEOUT, treat it as a valid read (no timeout).
REQ-015 SHALL in UPDATE pulse sample_valid for one cycle and update voltage_low[ch]: sample<LOW_TH -> 1; sample>HIGH_TH -> 0; otherwise (incl. equality to either threshold) hold.
REQ-016 SHALL compare thresholds as unsigned 12-bit values.
REQ-017 SHALL after UPDATE advance ch to (ch+1) mod NUM_CH and return to IDLE; ch wraps NUM_CH-1 -> 0.
REQ-018 SHALL leave voltage_low bits of non-current channels unchanged in every cycle.
REQ-019 SHALL keep timeout_err set until reset.
REQ-020 SHALL drive busy=1 in ISSUE, WAIT, UPDATE; 0 in IDLE.
REQ-021 SHALL give minimum latency eoc_in -> sample_valid of drdy delay + 3 cycles (drdy in first WAIT cycle: sample_valid 3 cycles after eoc_in).

Reset
REQ-022 SHALL on reset_in asynchronously force state=IDLE, ch=0, den_out=0, daddr_out=BASE_ADDR, sample_out=0, sample_ch_out=0, sample_valid=0, voltage_low=0, timeout_err=0, busy=0, wait counter=0.
REQ-023 SHALL on reset asserted mid-WAIT abort the transaction with no sample_valid, and ignore any drdy_in arriving after release until a new ISSUE.

Verification
REQ-024 Single read: eoc_in pulse, drdy_in 2 cycles after den_out, do_in=16'hE000 -> daddr_out=7'h10, sample_out=12'hE00, sample_valid one cycle, voltage_low[0]=1.
REQ-025 Hysteresis: ch0 sequence E00, E2B, E3C, E3D, E2B -> voltage_low[0] = 1,1,1,0,0.
REQ-026 Round-robin: 5 conversions, NUM_CH=4 -> daddr_out 7'h10,11,12,13,10; sample_ch_out 0,1,2,3,0.
REQ-027 Timeout: no drdy_in after den_out -> after 63 WAIT cycles timeout_err=1, no sample_valid, next eoc_in reads ch1.
REQ-028 Collisions: eoc_in during WAIT ignored; drdy_in in IDLE produces no sample_valid.
REQ-029 Reset mid-WAIT: assert reset_in 1 cycle, then drdy_in -> no sample_valid, all outputs at REQ-022 values, next read at 7'h10.

Source files
------------

// File: rtl/xadc_channel_scheduler.sv
// Round-robin XADC aux-channel reader: one DRP read per end-of-conversion,
// with per-channel low-voltage hysteresis and a sticky DRP timeout flag.
module xadc_channel_scheduler #(
    parameter int          NUM_CH    = 4,
    parameter logic [6:0]  BASE_ADDR = 7'h10,
    parameter logic [11:0] LOW_TH    = 12'hE1A,
    parameter logic [11:0] HIGH_TH   = 12'hE3C,
    parameter int          TIMEOUT   = 63
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              eoc_in,
    output logic              den_out,
    output logic [6:0]        daddr_out,
    input  logic              drdy_in,
    input  logic [15:0]       do_in,
    output logic [11:0]       sample_out,
    output logic [2:0]        sample_ch_out,
    output logic              sample_valid,
    output logic [NUM_CH-1:0] voltage_low,
    output logic              timeout_err,
    output logic              busy
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        ch_q, ch_d, ch_nxt;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              den_q, den_d;
    logic [6:0]        daddr_q, daddr_d;
    logic [11:0]       sample_q, sample_d;
    logic [2:0]        sch_q, sch_d;
    logic              valid_q, valid_d;
    logic [NUM_CH-1:0] vl_q, vl_d;
    logic              terr_q, terr_d;
    logic              busy_q, busy_d;
    logic [11:0]       rd_val;

    assign rd_val = do_in[15:4];
    assign ch_nxt = (ch_q == 3'(NUM_CH - 1)) ? 3'd0 : ch_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        den_d    = 1'b0;
        daddr_d  = daddr_q;
        sample_d = sample_q;
        sch_d    = sch_q;
        valid_d  = 1'b0;
        vl_d     = vl_q;
        terr_d   = terr_q;
        unique case (state_q)
            IDLE: begin
                if (eoc_in) begin
                    state_d = ISSUE;
                    den_d   = 1'b1;
                    daddr_d = BASE_ADDR + {4'b0, ch_q};
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // drdy on the final permitted cycle still counts as a read
                if (drdy_in) begin
                    state_d  = UPDATE;
                    sample_d = rd_val;
                    sch_d    = ch_q;
                    valid_d  = 1'b1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (3'(i) == ch_q) begin
                            if (rd_val < LOW_TH)
                                vl_d[i] = 1'b1;
                            else if (rd_val > HIGH_TH)
                                vl_d[i] = 1'b0;
                        end
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                    ch_d    = ch_nxt;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            UPDATE: begin
                state_d = IDLE;
                ch_d    = ch_nxt;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            den_q    <= 1'b0;
            daddr_q  <= BASE_ADDR;
            sample_q <= '0;
            sch_q    <= '0;
            valid_q  <= 1'b0;
            vl_q     <= '0;
            terr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            den_q    <= den_d;
            daddr_q  <= daddr_d;
            sample_q <= sample_d;
            sch_q    <= sch_d;
            valid_q  <= valid_d;
            vl_q     <= vl_d;
            terr_q   <= terr_d;
            busy_q   <= busy_d;
        end
    end

    assign den_out       = den_q;
    assign daddr_out     = daddr_q;
    assign sample_out    = sample_q;
    assign sample_ch_out = sch_q;
    assign sample_valid  = valid_q;
    assign voltage_low   = vl_q;
    assign timeout_err   = terr_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_xadc_channel_scheduler.sv
// Scoreboard bench for xadc_channel_scheduler: expected samples queued on
// drdy, popped when sample_valid appears.
module tb_xadc_channel_scheduler;

    localparam int         NUM_CH = 4;
    localparam logic [6:0] BASE   = 7'h10;
    localparam int         TO     = 63;

    logic              clk = 1'b0;
    logic              reset_in;
    logic              eoc_in;
    logic              den_out;
    logic [6:0]        daddr_out;
    logic              drdy_in;
    logic [15:0]       do_in;
    logic [11:0]       sample_out;
    logic [2:0]        sample_ch_out;
    logic              sample_valid;
    logic [NUM_CH-1:0] voltage_low;
    logic              timeout_err;
    logic              busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  ch;
        logic [11:0] val;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [NUM_CH-1:0] vl_model;
    int                ch_model;

    xadc_channel_scheduler #(
        .NUM_CH(NUM_CH), .BASE_ADDR(BASE),
        .LOW_TH(12'hE1A), .HIGH_TH(12'hE3C), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_in(reset_in), .eoc_in(eoc_in),
        .den_out(den_out), .daddr_out(daddr_out),
        .drdy_in(drdy_in), .do_in(do_in),
        .sample_out(sample_out), .sample_ch_out(sample_ch_out),
        .sample_valid(sample_valid), .voltage_low(voltage_low),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset_in && sample_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample_valid: got ch %0d val %h, required no pulse",
                         sample_ch_out, sample_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (sample_out !== mon_e.val || sample_ch_out !== mon_e.ch) begin
                    errors++;
                    $display("FAIL sample: got ch %0d val %h, required ch %0d val %h",
                             sample_ch_out, sample_out, mon_e.ch, mon_e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic hyst(input logic old, input logic [11:0] v);
        if (v < 12'hE1A) return 1'b1;
        if (v > 12'hE3C) return 1'b0;
        return old;
    endfunction

    task automatic do_read(input logic [11:0] val, input int delay, output logic [6:0] addr);
        int n;
        logic [6:0] exp_addr;
        exp_addr = BASE + 7'(ch_model);
        eoc_in = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!den_out && n < 10);
        eoc_in = 1'b0;
        addr = daddr_out;
        checks++;
        if (den_out !== 1'b1 || n != 1) begin
            errors++;
            $display("FAIL den_issue: got den %b after %0d cycles, required 1 after 1", den_out, n);
        end
        checks++;
        if (daddr_out !== exp_addr) begin
            errors++;
            $display("FAIL daddr: got %h, required %h", daddr_out, exp_addr);
        end
        for (int i = 0; i < delay; i++) tick();
        checks++;
        if (den_out !== 1'b0 || daddr_out !== exp_addr || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_state: got den %b addr %h busy %b, required 0 %h 1",
                     den_out, daddr_out, busy, exp_addr);
        end
        drdy_in = 1'b1;
        do_in = {val, 4'($urandom)};
        exp_q.push_back({3'(ch_model), val});
        vl_model[ch_model] = hyst(vl_model[ch_model], val);
        tick();
        drdy_in = 1'b0;
        checks++;
        if (sample_valid !== 1'b1) begin
            errors++;
            $display("FAIL sample_valid_latency: got %b, required 1", sample_valid);
        end
        tick();
        checks++;
        if (sample_valid !== 1'b0 || busy !== 1'b0 || voltage_low !== vl_model) begin
            errors++;
            $display("FAIL post_read: got valid %b busy %b vl %b, required 0 0 %b",
                     sample_valid, busy, voltage_low, vl_model);
        end
        ch_model = (ch_model + 1) % NUM_CH;
    endtask

    task automatic align_ch0();
        logic [6:0] a;
        while (ch_model != 0) do_read(12'h800, 1, a);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (den_out !== 1'b0 || daddr_out !== BASE || sample_out !== 12'h0 ||
            sample_ch_out !== 3'd0 || sample_valid !== 1'b0 || voltage_low !== '0 ||
            timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got den %b addr %h smp %h ch %0d v %b vl %b terr %b busy %b, required 0 10 000 0 0 0 0 0",
                     tag, den_out, daddr_out, sample_out, sample_ch_out, sample_valid,
                     voltage_low, timeout_err, busy);
        end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        eoc_in = 1'b0;
        drdy_in = 1'b0;
        do_in = '0;
        vl_model = '0;
        ch_model = 0;
        tick();
        tick();
        check_reset_values("reset_state");
        reset_in = 1'b0;
        tick();
        check_reset_values("after_release");
    endtask

    task automatic test_single_read();
        logic [6:0] a;
        do_read(12'hE00, 2, a);
        checks++;
        if (a !== 7'h10 || sample_out !== 12'hE00 || voltage_low[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_read: got addr %h smp %h vl0 %b, required 10 E00 1",
                     a, sample_out, voltage_low[0]);
        end
    endtask

    task automatic test_hysteresis();
        logic [11:0] hv[5] = '{12'hE00, 12'hE2B, 12'hE3C, 12'hE3D, 12'hE2B};
        logic        he[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [6:0]  a;
        for (int i = 0; i < 5; i++) begin
            align_ch0();
            do_read(hv[i], 1, a);
            checks++;
            if (voltage_low[0] !== he[i]) begin
                errors++;
                $display("FAIL hysteresis[%0d]: got %b, required %b", i, voltage_low[0], he[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [6:0] ra[5] = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h10};
        logic [2:0] rc[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [6:0] a;
        align_ch0();
        for (int i = 0; i < 5; i++) begin
            do_read(12'($urandom), 1 + i % 3, a);
            checks++;
            if (a !== ra[i] || sample_ch_out !== rc[i]) begin
                errors++;
                $display("FAIL round_robin[%0d]: got addr %h ch %0d, required %h %0d",
                         i, a, sample_ch_out, ra[i], rc[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [11:0] prev;
        prev = sample_out;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pre: got %b, required 0", timeout_err);
        end
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!timeout_err && n < 200);
        checks++;
        if (timeout_err !== 1'b1 || n != TO + 1) begin
            errors++;
            $display("FAIL timeout_len: got terr %b after %0d cycles, required 1 after %0d",
                     timeout_err, n, TO + 1);
        end
        checks++;
        if (busy !== 1'b0 || sample_out !== prev || voltage_low !== vl_model) begin
            errors++;
            $display("FAIL timeout_state: got busy %b smp %h vl %b, required 0 %h %b",
                     busy, sample_out, voltage_low, prev, vl_model);
        end
        ch_model = (ch_model + 1) % NUM_CH;
    endtask

    task automatic test_late_drdy();
        logic [6:0] a;
        do_read(12'hFFF, TO, a);
        checks++;
        if (a !== 7'h11 || timeout_err !== 1'b1 || sample_out !== 12'hFFF) begin
            errors++;
            $display("FAIL late_drdy: got addr %h terr %b smp %h, required 11 1 FFF",
                     a, timeout_err, sample_out);
        end
    endtask

    task automatic test_collisions();
        logic den_seen;
        logic [11:0] prev;
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        tick();
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        drdy_in = 1'b1;
        do_in = 16'h5550;
        exp_q.push_back({3'(ch_model), 12'h555});
        vl_model[ch_model] = hyst(vl_model[ch_model], 12'h555);
        tick();
        drdy_in = 1'b0;
        tick();
        ch_model = (ch_model + 1) % NUM_CH;
        den_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            den_seen = den_seen | den_out | busy;
        end
        checks++;
        if (den_seen !== 1'b0) begin
            errors++;
            $display("FAIL eoc_in_wait: got den/busy activity %b, required 0", den_seen);
        end
        prev = sample_out;
        drdy_in = 1'b1;
        do_in = 16'hABC0;
        tick();
        drdy_in = 1'b0;
        tick();
        tick();
        checks++;
        if (sample_out !== prev || busy !== 1'b0 || voltage_low !== vl_model) begin
            errors++;
            $display("FAIL drdy_idle: got smp %h busy %b vl %b, required %h 0 %b",
                     sample_out, busy, voltage_low, prev, vl_model);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [6:0] a;
        eoc_in = 1'b1;
        tick();
        eoc_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        drdy_in = 1'b1;
        do_in = 16'h1230;
        tick();
        drdy_in = 1'b0;
        tick();
        check_reset_values("reset_mid_wait");
        vl_model = '0;
        ch_model = 0;
        do_read(12'hE50, 1, a);
        checks++;
        if (a !== 7'h10 || sample_ch_out !== 3'd0) begin
            errors++;
            $display("FAIL read_after_reset: got addr %h ch %0d, required 10 0", a, sample_ch_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] a;
        for (int i = 0; i < 8; i++) do_read(12'($urandom_range(12'hE00, 12'hE50)), 1 + i % 4, a);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_hysteresis();
        test_round_robin();
        align_ch0();
        test_timeout();
        test_late_drdy();
        test_collisions();
        test_reset_mid_wait();
        test_back_to_back();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
